// File: rtl/rom_scan_reader.sv
// PROM read engine for 556PT4/556PT5-family chips. It supports manual address
// stepping and an automatic full-chip scan, and registers every word it reads.
module rom_scan_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int LAST_ADDRESS  = 511,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [3:0] OP_READ = 4'b1100,
  parameter logic [3:0] OP_IDLE = 4'b1111
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     increment_address,
  input  logic                     decrement_address,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [3:0]               operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    data_line,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     scan_done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(LAST_ADDRESS);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            scanning;
  logic            start_prev, inc_prev, dec_prev;
  logic            start_edge, inc_edge, dec_edge;

  assign start_edge = start & ~start_prev;
  assign inc_edge   = increment_address & ~inc_prev;
  assign dec_edge   = decrement_address & ~dec_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_prev   <= 1'b0;
      inc_prev     <= 1'b0;
      dec_prev     <= 1'b0;
      address_line <= '0;
      data_line    <= '0;
      data_valid   <= 1'b0;
      scan_done    <= 1'b0;
      scanning     <= 1'b0;
      // Reset lands in SETTLE so that address 0 is read straight away.
      state        <= SETTLE;
      cnt          <= '0;
      busy         <= 1'b1;
      operation    <= OP_READ;
    end else begin
      start_prev <= start;
      inc_prev   <= increment_address;
      dec_prev   <= decrement_address;
      data_valid <= 1'b0;
      scan_done  <= 1'b0;
      case (state)
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            data_line  <= data_line_in;
            data_valid <= 1'b1;
            if (scanning && address_line != LAST_ADDR) begin
              address_line <= address_line + 1'b1;
              cnt          <= '0;
            end else begin
              scan_done <= scanning;
              scanning  <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
              operation <= OP_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (mode) begin
            if (start_edge) begin
              address_line <= '0;
              scanning     <= 1'b1;
              state        <= SETTLE;
              cnt          <= '0;
              busy         <= 1'b1;
              operation    <= OP_READ;
            end
          end else if (inc_edge != dec_edge) begin
            // Simultaneous up and down edges cancel out.
            if (inc_edge)
              address_line <= (address_line == LAST_ADDR) ? '0 : address_line + 1'b1;
            else
              address_line <= (address_line == '0) ? LAST_ADDR : address_line - 1'b1;
            state     <= SETTLE;
            cnt       <= '0;
            busy      <= 1'b1;
            operation <= OP_READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Directed bench for rom_scan_reader. It drives three configurations: 512x8,
// 256x4, and a short 8-word scan with a 2-cycle settle time.
module tb_rom_scan_reader;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] chip(input int a);
    return 8'((a * 37 + 11) ^ (a >> 2));
  endfunction

  // Instance A: 512x8, settle 4
  logic mode_a, start_a, inc_a, dec_a, dv_a, busy_a, done_a;
  logic [7:0] din_a, dout_a;
  logic [8:0] addr_a;
  logic [3:0] op_a;
  assign din_a = chip(int'(addr_a));
  rom_scan_reader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9), .LAST_ADDRESS(511), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .mode(mode_a), .start(start_a),
    .increment_address(inc_a), .decrement_address(dec_a), .data_line_in(din_a),
    .operation(op_a), .address_line(addr_a), .data_line(dout_a),
    .data_valid(dv_a), .busy(busy_a), .scan_done(done_a));

  // Instance B: 256x4, settle 4
  logic mode_b, start_b, inc_b, dec_b, dv_b, busy_b, done_b;
  logic [3:0] din_b, dout_b;
  logic [7:0] addr_b;
  logic [3:0] op_b;
  assign din_b = 4'(chip(int'(addr_b)));
  rom_scan_reader #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8), .LAST_ADDRESS(255), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .mode(mode_b), .start(start_b),
    .increment_address(inc_b), .decrement_address(dec_b), .data_line_in(din_b),
    .operation(op_b), .address_line(addr_b), .data_line(dout_b),
    .data_valid(dv_b), .busy(busy_b), .scan_done(done_b));

  // Instance C: 8 words, settle 2, auto scan
  logic mode_c, start_c, inc_c, dec_c, dv_c, busy_c, done_c;
  logic [7:0] din_c, dout_c;
  logic [2:0] addr_c;
  logic [3:0] op_c;
  assign din_c = chip(int'(addr_c));
  rom_scan_reader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .LAST_ADDRESS(7), .SETTLE_CYCLES(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .mode(mode_c), .start(start_c),
    .increment_address(inc_c), .decrement_address(dec_c), .data_line_in(din_c),
    .operation(op_c), .address_line(addr_c), .data_line(dout_c),
    .data_valid(dv_c), .busy(busy_c), .scan_done(done_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic dv_of(input int which);
    case (which)
      0: return dv_a;
      1: return dv_b;
      default: return dv_c;
    endcase
  endfunction

  // Returns the number of negedges until data_valid is seen (maxc+1 on timeout).
  task automatic wait_dv(input int which, input int maxc, output int n);
    n = maxc + 1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (dv_of(which)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int which, input int cyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (dv_of(which)) pulses++;
    end
  endtask

  int n, p;

  initial begin
    reset_n = 1'b0;
    mode_a = 0; start_a = 0; inc_a = 0; dec_a = 0;
    mode_b = 0; start_b = 0; inc_b = 0; dec_b = 0;
    mode_c = 1; start_c = 0; inc_c = 0; dec_c = 0;

    // Reset held 3 cycles, then the automatic read of address 0
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_op", 32'(op_a), 32'hC);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_dv", 32'(dv_a), 32'd0);
    wait_dv(0, 10, n);
    chk("rst_lat", 32'(n), 32'd4);
    chk("rst_data", 32'(dout_a), 32'(chip(0)));
    chk("rst_op_idle", 32'(op_a), 32'hF);
    chk("rst_busy_low", 32'(busy_a), 32'd0);
    $display("reset read: addr 0 data %0h latency %0d", dout_a, n);
    idle_cycles(0, 3, p);

    // Wrap down 0 -> 511, then up 511 -> 0
    dec_a = 1; @(negedge clk); dec_a = 0;
    chk("wrap_dn_addr", 32'(addr_a), 32'd511);
    wait_dv(0, 10, n);
    chk("wrap_dn_lat", 32'(n), 32'd4);
    chk("wrap_dn_data", 32'(dout_a), 32'(chip(511)));
    $display("dec: addr %0d data %0h", addr_a, dout_a);
    idle_cycles(0, 3, p);
    inc_a = 1; @(negedge clk); inc_a = 0;
    chk("wrap_up_addr", 32'(addr_a), 32'd0);
    wait_dv(0, 10, n);
    chk("wrap_up_data", 32'(dout_a), 32'(chip(0)));
    $display("inc: addr %0d data %0h", addr_a, dout_a);
    idle_cycles(0, 3, p);

    // Three spaced increment pulses
    for (int k = 1; k <= 3; k++) begin
      inc_a = 1; @(negedge clk); inc_a = 0;
      chk("step_addr", 32'(addr_a), 32'(k));
      wait_dv(0, 10, n);
      chk("step_lat", 32'(n), 32'd4);
      chk("step_data", 32'(dout_a), 32'(chip(k)));
      $display("step %0d: addr %0d data %0h", k, addr_a, dout_a);
      idle_cycles(0, 5, p);
    end

    // Increment held 20 cycles yields a single step
    inc_a = 1;
    idle_cycles(0, 20, p);
    inc_a = 0;
    idle_cycles(0, 3, n);
    chk("held_pulses", 32'(p + n), 32'd1);
    chk("held_addr", 32'(addr_a), 32'd4);
    $display("held increment: pulses %0d addr %0d", p + n, addr_a);

    // Simultaneous increment and decrement edges cancel
    inc_a = 1; dec_a = 1; @(negedge clk); inc_a = 0; dec_a = 0;
    chk("both_busy", 32'(busy_a), 32'd0);
    idle_cycles(0, 8, p);
    chk("both_pulses", 32'(p), 32'd0);
    chk("both_addr", 32'(addr_a), 32'd4);
    $display("inc+dec: pulses %0d addr %0d", p, addr_a);

    // Increment edge during SETTLE is discarded
    inc_a = 1; @(negedge clk); inc_a = 0;
    inc_a = 1; @(negedge clk); inc_a = 0;
    wait_dv(0, 10, n);
    chk("busy_edge_lat", 32'(n), 32'd3);
    chk("busy_edge_data", 32'(dout_a), 32'(chip(5)));
    idle_cycles(0, 8, p);
    chk("busy_edge_pulses", 32'(p), 32'd0);
    chk("busy_edge_addr", 32'(addr_a), 32'd5);
    $display("edge while busy: addr %0d extra pulses %0d", addr_a, p);

    // 256x4 wrap 0 -> 255 -> 0
    dec_b = 1; @(negedge clk); dec_b = 0;
    chk("b_dn_addr", 32'(addr_b), 32'd255);
    wait_dv(1, 10, n);
    chk("b_dn_lat", 32'(n), 32'd4);
    chk("b_dn_data", 32'(dout_b), 32'(chip(255) & 8'h0F));
    $display("b dec: addr %0d data %0h", addr_b, dout_b);
    idle_cycles(1, 3, p);
    inc_b = 1; @(negedge clk); inc_b = 0;
    chk("b_up_addr", 32'(addr_b), 32'd0);
    wait_dv(1, 10, n);
    chk("b_up_data", 32'(dout_b), 32'(chip(0) & 8'h0F));
    $display("b inc: addr %0d data %0h", addr_b, dout_b);

    // Auto scan of 8 words, with increment pulses ignored
    idle_cycles(2, 3, p);
    start_c = 1; @(negedge clk); start_c = 0;
    chk("scan_start_addr", 32'(addr_c), 32'd0);
    chk("scan_busy", 32'(busy_c), 32'd1);
    for (int i = 0; i < 8; i++) begin
      inc_c = ~inc_c;
      wait_dv(2, 6, n);
      chk("scan_lat", 32'(n), 32'd2);
      chk("scan_data", 32'(dout_c), 32'(chip(i)));
      chk("scan_done", 32'(done_c), 32'(i == 7));
      chk("scan_addr", 32'(addr_c), 32'((i == 7) ? 7 : i + 1));
      $display("scan word %0d: data %0h done %0d", i, dout_c, done_c);
    end
    chk("scan_end_busy", 32'(busy_c), 32'd0);
    idle_cycles(2, 6, p);
    chk("scan_end_pulses", 32'(p), 32'd0);
    chk("scan_end_addr", 32'(addr_c), 32'd7);

    // Reset in the middle of a scan at address 5
    start_c = 1; @(negedge clk); start_c = 0;
    for (int i = 0; i < 5; i++) begin
      wait_dv(2, 6, n);
      chk("abort_lat", 32'(n), 32'd2);
    end
    chk("abort_at_addr", 32'(addr_c), 32'd5);
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    chk("abort_addr", 32'(addr_c), 32'd0);
    chk("abort_busy", 32'(busy_c), 32'd1);
    wait_dv(2, 6, n);
    chk("abort_lat2", 32'(n), 32'd2);
    chk("abort_data", 32'(dout_c), 32'(chip(0)));
    chk("abort_done", 32'(done_c), 32'd0);
    chk("abort_idle", 32'(busy_c), 32'd0);
    p = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dv_c || done_c || busy_c) p++;
    end
    chk("abort_quiet", 32'(p), 32'd0);
    $display("reset mid-scan: addr %0d data %0h", addr_c, dout_c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_scan_reader.md
# rom_scan_reader

Parametrised PROM read engine for 556PT5 (3604, 512x8) and 556PT4 (3601, 256x4) chips and same-family parts. Drives address and operation lines to the chip socket, waits a programmable access time after every address change, and registers the chip data with a one-cycle valid strobe. Supports manual stepping (increment/decrement edges, wrap-around both ways) and an automatic full-chip scan for dumping. Sits between the board-level button/clock logic and the data sink (display or UART dumper).

## Interface
- DATA_WIDTH, 8: chip data width (4 for 3601).
- ADDRESS_WIDTH, 9: chip address width (8 for 3601).
- LAST_ADDRESS, 511: highest valid address (255 for 3601); must be ≤ 2^ADDRESS_WIDTH-1.
- SETTLE_CYCLES, 4: clk cycles from address change to data capture; ≥1.
- OP_READ, 4'b1100: operation code (V1..V4 = bits 0..3) while the chip is being read.
- OP_IDLE, 4'b1111: operation code while idle.
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- mode  in  1  0 = manual step, 1 = auto scan; sampled only in IDLE.
- start  in  1  rising edge starts auto scan (mode=1, IDLE only).
- increment_address  in  1  rising edge steps address +1 (manual, IDLE only).
- decrement_address  in  1  rising edge steps address -1 (manual, IDLE only).
- data_line_in  in  DATA_WIDTH  data from chip.
- operation  out  4  chip operation code.
- address_line  out  ADDRESS_WIDTH  chip address.
- data_line  out  DATA_WIDTH  last captured word.
- data_valid  out  1  one-cycle pulse: data_line was just updated.
- busy  out  1  high whenever state ≠ IDLE.
- scan_done  out  1  one-cycle pulse with the last word of an auto scan.

## Operation
- All outputs registered. Edge detection: one previous-value register per start/increment/decrement; edge = input & ~previous. Previous registers update every cycle, in every state, and clear in reset, so held levels never retrigger.
- States: IDLE, SETTLE. Counter cnt of width ≥ clog2(SETTLE_CYCLES+1).
- Reset (reset_n=0 at a posedge): address_line=0, data_line=0, data_valid=0, scan_done=0, state=SETTLE, cnt=0, busy=1, operation=OP_READ, scan flag cleared. Consequence: address 0 is read automatically after reset.
- Entering SETTLE always sets cnt=0 and operation=OP_READ. Each posedge in SETTLE: if cnt==SETTLE_CYCLES-1, capture data_line<=data_line_in, data_valid<=1, then exit; else cnt++.
- Exit from SETTLE: manual or post-reset -> IDLE, operation=OP_IDLE. Auto scan: if address==LAST_ADDRESS -> scan_done<=1, clear scan flag, IDLE; else address+1 and re-enter SETTLE (same posedge).
- IDLE, mode=0: increment edge alone -> address+1 (LAST_ADDRESS wraps to 0); decrement edge alone -> address-1 (0 wraps to LAST_ADDRESS); both edges same cycle -> no action. Any accepted step enters SETTLE.
- IDLE, mode=1: start edge -> address<=0, set scan flag, enter SETTLE. inc/dec ignored.
- Edges arriving while busy are discarded, not queued. mode changes while busy have no effect until IDLE. start while mode=0 ignored.
- Only reset aborts a scan; reset mid-scan restarts at address 0 as above.

## Timing
- Action posedge k (edge accepted): address_line new value visible after k; capture at posedge k+SETTLE_CYCLES; data_valid high for exactly one cycle after it.
- Auto scan: one word per SETTLE_CYCLES cycles; LAST_ADDRESS+1 data_valid pulses total; full 512-word scan at SETTLE_CYCLES=4 = 2048 cycles from start edge to scan_done.
- busy falls in the same cycle data_valid rises (end of manual read or scan); a new edge is accepted at the next posedge.
- address_line stays constant for all SETTLE_CYCLES cycles before each capture.

## Test plan
- Reset held 3 cycles, release -> address_line=0, operation=4'b1100, busy=1; data_valid pulse exactly 4 cycles after last reset posedge with data_line=chip[0]; then operation=4'b1111, busy=0.
- Manual: 3 single-cycle increment pulses spaced 10 cycles -> addresses 1,2,3, each followed 4 cycles later by data_valid with chip[n]; increment held high 20 cycles -> only one step.
- Wrap: decrement at address 0 -> address 511, data=chip[511]; increment -> 0. Repeat with DATA_WIDTH=4, ADDRESS_WIDTH=8, LAST_ADDRESS=255: 0 -> 255 -> 0.
- Simultaneous increment+decrement edges in IDLE -> address unchanged, no data_valid, busy stays 0; increment edge during SETTLE -> ignored.
- Auto scan, LAST_ADDRESS=7, SETTLE_CYCLES=2: start edge -> 8 data_valid pulses 2 cycles apart with chip[0..7], scan_done with the 8th only, then IDLE; inc pulses during scan ignored.
- Reset asserted mid-auto-scan at address 5 -> no scan_done, address 0, single post-reset read of chip[0], then IDLE.
